// File: rtl/load_align_unit.sv
// RV32I load unit: issues one word-aligned data-memory read per load and
// right-aligns / sign- or zero-extends the returned data for writeback.
module load_align_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] addr,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic        req_err;
   logic [31:0] sh;
   logic [31:0] ext;

   always_comb begin
      req_err = 1'b1;
      case (funct3)
         3'b000, 3'b100: req_err = 1'b0;
         3'b001, 3'b101: req_err = addr[0];
         3'b010:         req_err = |addr[1:0];
         default:        req_err = 1'b1;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid)  state_nx = req_err ? RESP : REQ;
         REQ:     if (mem_ack)    state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // lw is only ever issued aligned, so sh equals mem_rdata for that case
   always_comb begin
      sh  = mem_rdata >> {off_q, 3'b000};
      ext = sh;
      case (f3_q)
         3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ext = {24'b0, sh[7:0]};
         3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ext = {16'b0, sh[15:0]};
         default: ext = sh;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         off_q     <= '0;
         f3_q      <= '0;
         mem_addr  <= '0;
         resp_data <= '0;
         resp_rd   <= '0;
         resp_err  <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         off_q     <= addr[1:0];
         f3_q      <= funct3;
         mem_addr  <= {addr[31:2], 2'b00};
         resp_data <= '0;
         resp_rd   <= rd;
         resp_err  <= req_err;
      end else if (state == REQ && mem_ack) begin
         resp_data <= ext;
      end
   end

   assign req_ready  = (state == IDLE);
   assign mem_req    = (state == REQ);
   assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed vector table, hand-written
// corner sequences and randomized loads against a behavioural model.
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   load_align_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .addr       (addr),
      .funct3     (funct3),
      .rd         (rd),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] rdata;
      int          waits;
      int          hold;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: pick the addressed bytes arithmetically, then extend.
   function automatic void model(input logic [31:0] a, input logic [2:0] f,
                                 input logic [31:0] w, output logic [31:0] d,
                                 output logic e);
      int     sz;
      int     off;
      bit     sgn;
      longint v, lim;
      sz = 0; sgn = 0; off = int'(a[1:0]);
      case (f)
         3'd0: begin sz = 1; sgn = 1; end
         3'd1: begin sz = 2; sgn = 1; end
         3'd2: sz = 4;
         3'd4: sz = 1;
         3'd5: sz = 2;
         default: sz = 0;
      endcase
      if (sz == 0 || (off % sz) != 0) begin
         e = 1'b1; d = '0;
         return;
      end
      e   = 1'b0;
      v   = longint'(w) / (longint'(1) << (8 * off));
      lim = longint'(1) << (8 * sz);
      v   = v % lim;
      if (sgn && v >= lim / 2) v = v - lim;
      d = v[31:0];
   endfunction

   // One full load: issue, serve memory with 'waits' stall cycles, hold off
   // writeback for 'hold' cycles, then handshake and check all timing.
   task automatic run_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                           input logic [31:0] w, input int waits, input int hold,
                           input logic [31:0] exp_d, input logic exp_e);
      int          lat, nreq, wcnt, tmo;
      logic [31:0] maddr, d;
      logic        e;
      logic [4:0]  ro;
      tmo = 0;
      while (!req_ready && tmo < 20) begin
         @(negedge clk); tmo++;
      end
      chk("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; addr = a; funct3 = f; rd = r;
      @(negedge clk);
      req_valid = 1'b0; addr = $urandom; funct3 = 3'($urandom); rd = 5'($urandom);
      lat = 1; nreq = 0; wcnt = 0; maddr = '0;
      while (!resp_valid && lat < 60) begin
         if (mem_req) begin
            nreq++;
            if (nreq == 1) maddr = mem_addr;
            else chk("mem_addr_stable", mem_addr, maddr);
            mem_ack   = (wcnt == waits);
            mem_rdata = mem_ack ? w : $urandom;
            wcnt++;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end
         @(negedge clk);
         mem_ack = 1'b0;
         lat++;
      end
      chk("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
      chk("resp_latency", lat, exp_e ? 32'd1 : 32'(2 + waits));
      chk("mem_req_cycles", nreq, exp_e ? 32'd0 : 32'(waits + 1));
      if (!exp_e) chk("mem_addr", maddr, {a[31:2], 2'b00});
      chk("resp_data", resp_data, exp_d);
      chk("resp_err", {31'b0, resp_err}, {31'b0, exp_e});
      chk("resp_rd", {27'b0, resp_rd}, {27'b0, r});
      d = resp_data; e = resp_err; ro = resp_rd;
      for (int h = 0; h < hold; h++) begin
         resp_ready = 1'b0;
         mem_ack = 1'($urandom); mem_rdata = $urandom;
         @(negedge clk);
         mem_ack = 1'b0;
         chk("hold_valid", {31'b0, resp_valid}, 32'd1);
         chk("hold_data", resp_data, d);
         chk("hold_err", {31'b0, resp_err}, {31'b0, e});
         chk("hold_rd", {27'b0, resp_rd}, {27'b0, ro});
         chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      // a request offered during the handshake cycle must be ignored
      resp_ready = 1'b1;
      req_valid = 1'b1; addr = 32'h0000_0000; funct3 = 3'd0;
      @(negedge clk);
      resp_ready = 1'b0; req_valid = 1'b0;
      chk("post_hs_valid", {31'b0, resp_valid}, 32'd0);
      chk("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
      chk("post_hs_mem_req", {31'b0, mem_req}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, w, ed;
      logic [2:0]  f;
      logic        ee;

      vt[0]  = '{32'h0000_1003, 3'd0, 5'd1,  32'h80AA_55CC, 0, 0, 32'hFFFF_FF80, 1'b0};
      vt[1]  = '{32'h0000_2002, 3'd5, 5'd2,  32'hBEEF_1234, 3, 0, 32'h0000_BEEF, 1'b0};
      vt[2]  = '{32'h0000_0FFC, 3'd2, 5'd7,  32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 1'b0};
      vt[3]  = '{32'h0000_1001, 3'd2, 5'd3,  32'h1111_1111, 0, 0, 32'h0000_0000, 1'b1};
      vt[4]  = '{32'h0000_1003, 3'd1, 5'd4,  32'h2222_2222, 0, 0, 32'h0000_0000, 1'b1};
      vt[5]  = '{32'h0000_1000, 3'd3, 5'd5,  32'h3333_3333, 0, 0, 32'h0000_0000, 1'b1};
      vt[6]  = '{32'h0000_1001, 3'd4, 5'd6,  32'h80AA_55CC, 1, 0, 32'h0000_0055, 1'b0};
      vt[7]  = '{32'h0000_2000, 3'd1, 5'd8,  32'h1234_8765, 0, 1, 32'hFFFF_8765, 1'b0};
      vt[8]  = '{32'h0000_2000, 3'd5, 5'd9,  32'h1234_8765, 2, 0, 32'h0000_8765, 1'b0};
      vt[9]  = '{32'h0000_4000, 3'd6, 5'd10, 32'h4444_4444, 0, 0, 32'h0000_0000, 1'b1};
      vt[10] = '{32'h0000_4000, 3'd7, 5'd11, 32'h5555_5555, 0, 2, 32'h0000_0000, 1'b1};
      vt[11] = '{32'h0000_2001, 3'd5, 5'd31, 32'h6666_6666, 0, 0, 32'h0000_0000, 1'b1};

      rst = 1'b1; req_valid = 1'b0; addr = '0; funct3 = '0; rd = '0;
      mem_ack = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_resp_rd", {27'b0, resp_rd}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++)
         run_load(vt[i].a, vt[i].f3, vt[i].rd, vt[i].rdata, vt[i].waits, vt[i].hold,
                  vt[i].exp_data, vt[i].exp_err);

      // reset while waiting on memory; a late ack must not revive the load
      req_valid = 1'b1; addr = 32'h0000_3000; funct3 = 3'd2; rd = 5'd12;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid_mem_req", {31'b0, mem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("abandon_resp_valid", {31'b0, resp_valid}, 32'd0);
         chk("abandon_mem_req", {31'b0, mem_req}, 32'd0);
         chk("abandon_req_ready", {31'b0, req_ready}, 32'd1);
         @(negedge clk);
      end
      run_load(32'h0000_0001, 3'd0, 5'd13, 32'h1234_F0AB, 0, 0, 32'hFFFF_FFF0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         a = $urandom; w = $urandom; f = 3'($urandom_range(0, 7));
         model(a, f, w, ed, ee);
         run_load(a, f, 5'($urandom), w, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), ed, ee);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Execute-to-writeback load unit for the RV32I core. It takes the effective address produced by the ALU adder together with the load funct3, and issues one word-aligned read on the data-memory port. It then right-aligns and sign- or zero-extends the returned byte, halfword or word using the same right-shift-and-fill semantics as the ALU shifter, and hands the result to writeback over a valid/ready handshake. Misaligned and illegal loads complete with an error flag and never touch memory.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents a load
- req_ready  out  1  unit can accept; high only in IDLE
- addr  in  32  effective address from ALU
- funct3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others illegal
- rd  in  5  destination register tag
- mem_req  out  1  memory read request, held until acknowledged
- mem_addr  out  32  word-aligned read address {addr[31:2],2'b00}
- mem_ack  in  1  memory has data on mem_rdata this cycle
- mem_rdata  in  32  read word, valid only when mem_ack=1
- resp_valid  out  1  result available to writeback
- resp_ready  in  1  writeback accepts result
- resp_data  out  32  aligned, extended load value (0 when resp_err=1)
- resp_rd  out  5  tag of the completing load
- resp_err  out  1  misaligned or illegal funct3

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: req_ready=1. On req_valid, latch addr[1:0], funct3 and rd, and register mem_addr.
  - Legal and aligned -> REQ.
  - Otherwise -> RESP with resp_err=1 and resp_data=0.
- Misalignment rules:
  - lh/lhu with addr[0]=1.
  - lw with addr[1:0]!=0.
  - lb/lbu never misaligned.
  - funct3 011/110/111 is illegal.
- REQ: mem_req=1 and mem_addr stable.
  - On mem_ack=1, capture extracted data into resp_data, clear mem_req, then -> RESP.
  - Otherwise stay in REQ.
- Extraction:
  - sh = mem_rdata >> (8*addr[1:0]).
  - lb: {{24{sh[7]}},sh[7:0]}. lbu: {24'b0,sh[7:0]}.
  - lh: {{16{sh[15]}},sh[15:0]}. lhu: {16'b0,sh[15:0]}.
  - lw: mem_rdata unchanged.
- RESP: resp_valid=1. resp_data, resp_rd and resp_err are held stable until resp_ready=1, then -> IDLE.
- No request is accepted in the cycle resp_ready is sampled.
- mem_ack in IDLE or RESP is ignored.

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - mem_req=0, mem_addr=0.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
- Reset mid-operation (REQ or RESP) abandons the load. No resp_valid is produced for it, and a late mem_ack is ignored.
- Aligned load accepted in cycle T:
  - mem_req rises at T+1.
  - Zero-wait memory (mem_ack at T+1) gives resp_valid at T+2.
  - Each wait cycle adds one cycle.
- Error load accepted at T: resp_valid at T+1, and mem_req stays 0 throughout.
- Response handshake at cycle R (resp_valid && resp_ready): resp_valid low and req_ready high at R+1. Minimum throughput is therefore one load per 3 cycles.
- mem_req and mem_addr do not change while mem_req=1 and mem_ack=0.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- lb at addr 0x1003, mem_rdata 0x80AA55CC, zero-wait ack -> mem_addr 0x1000, resp_data 0xFFFFFF80, resp_err 0, resp_valid at T+2.
- lhu at addr 0x2002, mem_rdata 0xBEEF1234, ack after 3 wait cycles -> resp_data 0x0000BEEF, resp_valid at T+5, mem_req high for exactly 4 cycles.
- lw at 0x0FFC with rd=7, mem_rdata 0xDEADBEEF; hold resp_ready=0 for 4 cycles -> resp_data 0xDEADBEEF, resp_rd 7, all resp_* stable, req_ready 0 until the cycle after resp_ready=1.
- Misaligned and illegal:
  - lw at 0x1001 -> resp_err 1, resp_data 0, mem_req never asserted, resp_valid at T+1.
  - lh at 0x1003 -> resp_err 1, resp_data 0, mem_req never asserted, resp_valid at T+1.
  - funct3=011 -> resp_err 1, resp_data 0, mem_req never asserted, resp_valid at T+1.
- Reset during REQ, with mem_ack pulsed one cycle after rst deasserts -> no resp_valid, mem_req 0, req_ready 1.
- A new lb at 0x0001 then completes normally.
